// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns (active low, [6]=a .. [0]=g) for digits 0-9 and
// blank, the blank BCD code, and the reader FSM state type. Shared with the
// BCD-to-7-segment decoder so both ends agree on the glyph set.
package seg7_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HELD
  } rx_state_t;

endpackage

// File: rtl/seg7_to_bcd_reader_if.sv
// seg7_to_bcd_reader_if: the multiplexed display bus (active-low segments plus
// active-low one-hot anode strobes). The display driver is the master; the
// reader snoops as slave.
interface seg7_to_bcd_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]            seg_n;
  logic [NUM_DIGITS-1:0] an_n;

  modport master (output seg_n, output an_n);
  modport slave  (input  seg_n, input  an_n);
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment pattern to BCD lookup. Flags the
// all-off pattern as blank and anything outside the glyph set as illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       illegal
);

  // Table lookup; unknown patterns leave bcd at the blank code and raise illegal
  always_comb begin
    bcd     = BLANK_CODE;
    blank   = 1'b0;
    illegal = 1'b0;
    case (seg_n)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_to_bcd_reader.sv
// seg7_to_bcd_reader: snoops a multiplexed common-anode display bus and
// recovers one BCD digit per anode. A capture only happens after the sampled
// {an_n,seg_n} has been identical long enough, so scan edges are never latched.
// Optional per-digit refresh timeout is enabled by defining SEG7_RX_TIMEOUT_EN.
module seg7_to_bcd_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg7_to_bcd_reader_if.slave     disp,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int SMP_W = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SMP_W-1:0]      raw;
  logic [SMP_W-1:0]      sample_q;
  logic [CNT_W-1:0]      stab_cnt;
  logic                  changed;
  logic                  one_hot;
  logic                  capture;
  logic [NUM_DIGITS-1:0] an_low;
  logic [NUM_DIGITS-1:0] cap_bits;
  logic [NUM_DIGITS-1:0] refresh_mask;
  logic [3:0]            dec_bcd;
  logic                  dec_blank;
  logic                  dec_illegal;
  rx_state_t             state;
  rx_state_t             state_next;

  assign raw      = {disp.an_n, disp.seg_n};
  assign changed  = (raw != sample_q);
  assign an_low   = ~sample_q[SMP_W-1:7];
  assign one_hot  = $onehot(an_low);
  assign cap_bits = capture ? an_low : '0;

  seg7_pattern_decode u_decode (
    .seg_n   (sample_q[6:0]),
    .bcd     (dec_bcd),
    .blank   (dec_blank),
    .illegal (dec_illegal)
  );

  // Register the bus every cycle and count how long it has stayed unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '1;
      stab_cnt <= '0;
    end else begin
      sample_q <= raw;
      if (changed)
        stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX)
        stab_cnt <= stab_cnt + CNT_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next state; CAPTURE also re-enters SETTLE if the bus moves during it
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      ST_IDLE:
        if (one_hot) state_next = ST_SETTLE;
      ST_SETTLE:
        if (!one_hot)                            state_next = ST_IDLE;
        else if (!changed && stab_cnt == CNT_MAX) state_next = ST_CAPTURE;
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = changed ? ST_SETTLE : ST_HELD;
      end
      ST_HELD:
        if (!one_hot)    state_next = ST_IDLE;
        else if (changed) state_next = ST_SETTLE;
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef SEG7_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt [NUM_DIGITS];

  // Per-digit refresh age, restarted by each capture of that digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) to_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_bits[k])
          to_cnt[k] <= '0;
        else if (to_cnt[k] != TO_MAX)
          to_cnt[k] <= to_cnt[k] + TO_W'(1);
      end
    end
  end
`endif

  // Digit store: illegal patterns keep the old value but flag the error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out     <= '1;
      digit_valid <= '0;
      digit_err   <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_bits[k]) begin
          digit_valid[k] <= 1'b1;
          digit_err[k]   <= dec_illegal;
          if (!dec_illegal)
            bcd_out[4*k +: 4] <= dec_blank ? BLANK_CODE : dec_bcd;
        end
`ifdef SEG7_RX_TIMEOUT_EN
        else if (to_cnt[k] == TO_MAX) begin
          digit_valid[k]    <= 1'b0;
          bcd_out[4*k +: 4] <= BLANK_CODE;
        end
`endif
      end
    end
  end

  // Refresh mask; a full mask pulses frame_done and restarts with any new capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_mask <= '0;
      frame_done   <= 1'b0;
    end else if (&refresh_mask) begin
      refresh_mask <= cap_bits;
      frame_done   <= 1'b1;
    end else begin
      refresh_mask <= refresh_mask | cap_bits;
      frame_done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_reader.sv
// tb_seg7_to_bcd_reader: directed bench for seg7_to_bcd_reader with a
// scoreboard of expected digit-store snapshots. Define SEG7_RX_TIMEOUT_EN to
// build the timeout variant (bench then uses TIMEOUT_CYCLES=16).
module tb_seg7_to_bcd_reader;

`ifdef SEG7_RX_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic [3:0]  err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_err;
  logic        frame_done;

  int   errors;
  int   checks;
  int   frame_cnt;
  exp_t exp_q[$];

  logic [15:0] model_bcd;
  logic [3:0]  model_valid;
  logic [3:0]  model_err;

  seg7_to_bcd_reader_if #(.NUM_DIGITS(4)) bus ();

  seg7_to_bcd_reader #(
    .NUM_DIGITS     (4),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp        (bus),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .frame_done  (frame_done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses just after each rising edge
  initial frame_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) frame_cnt++;
  end

  function automatic int refDecode(input logic [6:0] seg);
    case (seg)
      7'b0000001: return 0;
      7'b1001111: return 1;
      7'b0010010: return 2;
      7'b0000110: return 3;
      7'b1001100: return 4;
      7'b0100100: return 5;
      7'b0100000: return 6;
      7'b0001111: return 7;
      7'b0000000: return 8;
      7'b0000100: return 9;
      7'b1111111: return 15;
      default:    return -1;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg);
    bus.an_n  = an;
    bus.seg_n = seg;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Update the reference store for a capture of digit k and queue the snapshot
  task automatic modelCapture(input int k, input logic [6:0] seg);
    int d;
    exp_t e;
    d = refDecode(seg);
    model_valid[k] = 1'b1;
    if (d < 0) begin
      model_err[k] = 1'b1;
    end else begin
      model_err[k] = 1'b0;
      model_bcd[4*k +: 4] = d[3:0];
    end
    e.bcd   = model_bcd;
    e.valid = model_valid;
    e.err   = model_err;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the store to change, then compare against the queue head
  task automatic waitCapture(input string tag, input int lat);
    logic [23:0] snap;
    int n;
    bit seen;
    exp_t e;
    snap = {bcd_out, digit_valid, digit_err};
    seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if ({bcd_out, digit_valid, digit_err} !== snap) seen = 1'b1;
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, n, lat);
    e = exp_q.pop_front();
    checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'(e.bcd));
    checkOutput({tag, "_valid"}, 32'(digit_valid), 32'(e.valid));
    checkOutput({tag, "_err"}, 32'(digit_err), 32'(e.err));
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'(model_bcd));
    checkOutput({tag, "_valid"}, 32'(digit_valid), 32'(model_valid));
    checkOutput({tag, "_err"}, 32'(digit_err), 32'(model_err));
  endtask

  initial begin
    logic [3:0] scan_an  [4];
    logic [6:0] scan_seg [4];
    int f0;

    scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    scan_seg = '{7'b1001111, 7'b0000100, 7'b1111111, 7'b0001111};
    errors = 0;
    checks = 0;
    model_bcd   = 16'hFFFF;
    model_valid = 4'b0000;
    model_err   = 4'b0000;

    // Reset state
    rst_n = 1'b0;
    applyStimulus(4'b1111, 7'b1111111);
    waitCycles(3);
    checkOutput("rst_bcd", 32'(bcd_out), 32'h0000FFFF);
    checkOutput("rst_valid", 32'(digit_valid), 32'd0);
    checkOutput("rst_err", 32'(digit_err), 32'd0);
    checkOutput("rst_frame", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    waitCycles(2);

    // Single digit '2' on anode 0: not visible after t+4, visible after t+5
    applyStimulus(4'b1110, 7'b0010010);
    modelCapture(0, 7'b0010010);
    waitCycles(5);
    checkOutput("t1_early_valid", 32'(digit_valid), 32'd0);
    waitCapture("t1", 1);

    // Scan 1, 9, blank, 7 with 6-cycle holds
    f0 = frame_cnt;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(scan_an[i], scan_seg[i]);
      modelCapture(i, scan_seg[i]);
      waitCapture($sformatf("t2_d%0d", i), 6);
    end
    applyStimulus(4'b1111, 7'b1111111);
    waitCycles(3);
    checkOutput("t2_final_bcd", 32'(bcd_out), 32'h00007F91);
    checkOutput("t2_frames", frame_cnt - f0, 32'd1);

    // Illegal pattern on digit 1, then a legal one clears the error
    applyStimulus(4'b1101, 7'b1111110);
    modelCapture(1, 7'b1111110);
    waitCapture("t3_illegal", 6);
    applyStimulus(4'b1101, 7'b0000110);
    modelCapture(1, 7'b0000110);
    waitCapture("t3_legal", 6);

    // Ghosting (two anodes low) and a fast-toggling pattern never capture
    f0 = frame_cnt;
    applyStimulus(4'b1100, 7'b0000000);
    waitCycles(10);
    checkModel("t4_ghost");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1110, (i % 2 == 0) ? 7'b0000000 : 7'b0100100);
      waitCycles(2);
    end
    applyStimulus(4'b1111, 7'b1111111);
    waitCycles(6);
    checkModel("t4_toggle");
    checkOutput("t4_frames", frame_cnt - f0, 32'd0);

    // Async reset while settling, then a normal capture afterwards
    applyStimulus(4'b1011, 7'b1001100);
    waitCycles(2);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_bcd", 32'(bcd_out), 32'h0000FFFF);
    checkOutput("t5_rst_valid", 32'(digit_valid), 32'd0);
    checkOutput("t5_rst_err", 32'(digit_err), 32'd0);
    model_bcd   = 16'hFFFF;
    model_valid = 4'b0000;
    model_err   = 4'b0000;
    waitCycles(2);
    rst_n = 1'b1;
    modelCapture(2, 7'b1001100);
    waitCapture("t5_after", 6);

    // Stop strobing: timeout variant drops digit 2 sixteen cycles after capture
    applyStimulus(4'b1111, 7'b1111111);
`ifdef SEG7_RX_TIMEOUT_EN
    waitCycles(15);
    checkOutput("t6_before_valid", 32'(digit_valid), 32'h4);
    waitCycles(1);
    checkOutput("t6_after_valid", 32'(digit_valid), 32'h0);
    checkOutput("t6_after_bcd", 32'(bcd_out), 32'h0000FFFF);
`else
    waitCycles(40);
    checkOutput("t6_sticky_valid", 32'(digit_valid), 32'h4);
    checkOutput("t6_sticky_bcd", 32'(bcd_out), 32'h0000F4FF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
